instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter INSTR_W, default 24, instruction width: opcode[23:18], mode[17:16], reg[15:12], imm[11:0].
REQ-002 Parameter MEM_DEPTH, default 16, instruction memory entries.
REQ-003 Parameter PC_W, default 4, program counter width; MEM_DEPTH SHALL equal 2**PC_W.
REQ-004 Parameter HALT_OP, default 6'b111111, opcode that halts fetch.
REQ-005 clk  input  1  single clock; all state on posedge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 load_en  input  1  write strobe for instruction memory.
REQ-008 load_addr  input  PC_W  memory write address.
REQ-009 load_data  input  INSTR_W  memory write data.
REQ-010 start  input  1  one-cycle pulse, begins fetch at pc 0.
REQ-011 fetch_next  input  1  stall from hazard_detection; 1 = hold, 0 = advance.
REQ-012 redirect_valid  input  1  branch/jump taken.
REQ-013 redirect_pc  input  PC_W  branch target.
REQ-014 instruction_out  output  INSTR_W  fetched instruction to hazard_detection instruction_in.
REQ-015 instr_valid  output  1  instruction_out carries a real instruction.
REQ-016 pc_out  output  PC_W  address of instruction_out.
REQ-017 halted  output  1  fetch unit in HALT state.

Function
REQ-018 State machine SHALL have states LOAD, RUN, HALT.
REQ-019 LOAD: load_en writes load_data to mem[load_addr] on posedge; outputs stay at reset values.
REQ-020 LOAD or HALT with start=1: next state RUN, pc <= 0, memory unchanged; same-cycle load_en write still completes.
REQ-021 RUN, fetch_next=0, no redirect: instruction_out <= mem[pc], pc_out <= pc, instr_valid <= 1, pc <= pc+1 mod MEM_DEPTH (15 wraps to 0).
REQ-022 Latency: mem[pc] appears on instruction_out exactly 1 cycle after the advancing edge.
REQ-023 RUN, fetch_next=1: instruction_out, pc_out, instr_valid and pc SHALL hold unchanged.
REQ-024 RUN, redirect_valid=1: pc <= redirect_pc, instruction_out <= 0 (NOP), instr_valid <= 0 for one cycle; redirect overrides fetch_next.
REQ-025 When an instruction with opcode HALT_OP is emitted, it SHALL be presented with instr_valid=1; next posedge state <= HALT, instr_valid <= 0, pc frozen.
REQ-026 HALT: halted=1; fetch_next and redirect_valid ignored; only start or reset leaves HALT.
REQ-027 load_en in RUN or HALT SHALL be ignored; start in RUN SHALL be ignored.
REQ-028 Redirect arriving the same cycle a HALT_OP would be fetched: redirect wins, HALT_OP not emitted.

Reset
REQ-029 rst_n low SHALL immediately force state LOAD, pc=0, instruction_out=0, pc_out=0, instr_valid=0, halted=0.
REQ-030 Memory contents SHALL NOT be cleared by reset.
REQ-031 Reset asserted mid-RUN SHALL abort fetch; no instruction emitted until a new start.

Structure
REQ-032 Shared package SHALL hold INSTR_W, opcode/field bit positions, HALT_OP, NOP encoding, state encoding.
REQ-033 Sub-module instr_mem (synchronous write, combinational read, MEM_DEPTH x INSTR_W) SHALL be instantiated; FSM and PC live in instruction_fetch.

Verification
REQ-034 Load mem[0..3] = 0x004004, 0x113006, 0x0C6008, 0x123006, start -> instruction_out sequence 0x004004, 0x113006, 0x0C6008, 0x123006, pc_out 0..3, instr_valid=1 each cycle.
REQ-035 fetch_next=1 for 3 cycles while 0x113006 is out -> instruction_out and pc_out=1 held 3 cycles, then 0x0C6008 follows.
REQ-036 redirect_valid with redirect_pc=9 while fetch_next=1 -> one NOP cycle with instr_valid=0, then mem[9], pc_out=9.
REQ-037 mem[2]=0xFC0000 (HALT_OP) -> emitted once with instr_valid=1, then halted=1, instr_valid=0, outputs stable for 10 cycles; start -> restart at pc 0.
REQ-038 Run through pc 15 -> next pc_out=0 (wrap).
REQ-039 rst_n low mid-RUN at pc 5 -> outputs zero immediately; after release and start, memory intact and fetch restarts at pc 0.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
// Covers the instruction field layout, the halt opcode, the NOP encoding and the fetch FSM states.
package instruction_fetch_pkg;

  localparam int INSTR_W    = 24;
  localparam int OPCODE_LSB = 18;
  localparam int OPCODE_W   = 6;
  localparam int MODE_LSB   = 16;
  localparam int MODE_W     = 2;
  localparam int REG_LSB    = 12;
  localparam int REG_W      = 4;
  localparam int IMM_LSB    = 0;
  localparam int IMM_W      = 12;

  localparam logic [OPCODE_W-1:0] HALT_OP = 6'b111111;
  localparam logic [INSTR_W-1:0]  NOP     = '0;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_instr_mem.sv
// Instruction memory for the fetch unit.
// It has a synchronous write port and a combinational read port.
module instr_mem #(
  parameter int INSTR_W   = instruction_fetch_pkg::INSTR_W,
  parameter int MEM_DEPTH = 16,
  parameter int ADDR_W    = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: loads a program in LOAD, streams mem[pc] in RUN, and stops on a halt opcode.
// Memory is deliberately not reset, so a program survives reset and restart.
module instruction_fetch #(
  parameter int INSTR_W   = instruction_fetch_pkg::INSTR_W,
  parameter int MEM_DEPTH = 16,
  parameter int PC_W      = 4,
  parameter logic [instruction_fetch_pkg::OPCODE_W-1:0] HALT_OP = instruction_fetch_pkg::HALT_OP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_en,
  input  logic [PC_W-1:0]    load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  input  logic               fetch_next,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [INSTR_W-1:0] instruction_out,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc_out,
  output logic               halted
);
  import instruction_fetch_pkg::*;

  fetch_state_e       state_reg;
  logic [PC_W-1:0]    pc_reg;
  logic [PC_W-1:0]    pc_out_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic               valid_reg;
  logic               halted_reg;
  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_we;
  logic               halt_seen;

  // Writes are only accepted while loading; a start in the same cycle still lets the write land.
  assign mem_we    = load_en && (state_reg == ST_LOAD);
  assign halt_seen = valid_reg && (instr_reg[OPCODE_LSB +: OPCODE_W] == HALT_OP);

  instr_mem #(
    .INSTR_W   (INSTR_W),
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (PC_W)
  ) u_instr_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_reg),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_LOAD;
      pc_reg     <= '0;
      pc_out_reg <= '0;
      instr_reg  <= '0;
      valid_reg  <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_LOAD: begin
          if (start) begin
            state_reg <= ST_RUN;
            pc_reg    <= '0;
          end
        end
        ST_RUN: begin
          // A halt opcode already presented takes priority over any stall or redirect.
          if (halt_seen) begin
            state_reg  <= ST_HALT;
            valid_reg  <= 1'b0;
            halted_reg <= 1'b1;
          end else if (redirect_valid) begin
            pc_reg    <= redirect_pc;
            instr_reg <= INSTR_W'(NOP);
            valid_reg <= 1'b0;
          end else if (!fetch_next) begin
            instr_reg  <= mem_rdata;
            pc_out_reg <= pc_reg;
            valid_reg  <= 1'b1;
            pc_reg     <= pc_reg + PC_W'(1);
          end
        end
        ST_HALT: begin
          if (start) begin
            state_reg  <= ST_RUN;
            pc_reg     <= '0;
            halted_reg <= 1'b0;
          end
        end
        default: state_reg <= ST_LOAD;
      endcase
    end
  end

  assign instruction_out = instr_reg;
  assign instr_valid     = valid_reg;
  assign pc_out          = pc_out_reg;
  assign halted          = halted_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a table of directed cycles, hand-written halt/reset sequences,
// and a randomized run checked against a cycle-level reference model.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [23:0] load_data;
  logic        start;
  logic        fetch_next;
  logic        redirect_valid;
  logic [3:0]  redirect_pc;
  logic [23:0] instruction_out;
  logic        instr_valid;
  logic [3:0]  pc_out;
  logic        halted;

  int total = 0;
  int bad   = 0;

  instruction_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_en         (load_en),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .start           (start),
    .fetch_next      (fetch_next),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instruction_out (instruction_out),
    .instr_valid     (instr_valid),
    .pc_out          (pc_out),
    .halted          (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the program image plus what the fetch unit should be showing.
  logic [23:0] m_mem [16];
  int          m_mode;      // 0 = accepting program, 1 = fetching, 2 = stopped
  int          m_pc;
  int          m_pcout;
  logic [23:0] m_instr;
  logic        m_valid;
  logic        m_halted;

  function automatic void model_reset();
    m_mode   = 0;
    m_pc     = 0;
    m_pcout  = 0;
    m_instr  = '0;
    m_valid  = 1'b0;
    m_halted = 1'b0;
  endfunction

  function automatic void model_update();
    bit stop_now;
    stop_now = m_valid && (m_instr[23:18] == 6'h3F);
    if (m_mode == 0 && load_en) m_mem[load_addr] = load_data;
    if (m_mode != 1) begin
      if (start) begin
        m_mode   = 1;
        m_pc     = 0;
        m_halted = 1'b0;
      end
    end else if (stop_now) begin
      m_mode   = 2;
      m_halted = 1'b1;
      m_valid  = 1'b0;
    end else if (redirect_valid) begin
      m_pc    = int'(redirect_pc);
      m_instr = 24'h0;
      m_valid = 1'b0;
    end else if (!fetch_next) begin
      m_instr = m_mem[m_pc];
      m_pcout = m_pc;
      m_valid = 1'b1;
      m_pc    = (m_pc + 1) % 16;
    end
  endfunction

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ld, input logic [3:0] la, input logic [23:0] ldat,
                        input logic st, input logic fn, input logic rv, input logic [3:0] rpc);
    load_en = ld; load_addr = la; load_data = ldat;
    start = st; fetch_next = fn; redirect_valid = rv; redirect_pc = rpc;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [23:0] ei, input logic ev,
                            input logic [3:0] ep, input logic eh);
    check({tag, ".instr"},  32'(instruction_out), 32'(ei));
    check({tag, ".valid"},  32'(instr_valid),     32'(ev));
    check({tag, ".pc_out"}, 32'(pc_out),          32'(ep));
    check({tag, ".halted"}, 32'(halted),          32'(eh));
  endtask

  typedef struct {
    logic        ld;
    logic [3:0]  la;
    logic [23:0] ldat;
    logic        st;
    logic        fn;
    logic        rv;
    logic [3:0]  rpc;
    logic [23:0] e_instr;
    logic        e_valid;
    logic [3:0]  e_pc;
    logic        e_halt;
  } vec_t;

  function automatic vec_t mk(logic ld, logic [3:0] la, logic [23:0] ldat, logic st, logic fn,
                              logic rv, logic [3:0] rpc, logic [23:0] ei, logic ev,
                              logic [3:0] ep, logic eh);
    vec_t r;
    r.ld = ld; r.la = la; r.ldat = ldat; r.st = st; r.fn = fn; r.rv = rv; r.rpc = rpc;
    r.e_instr = ei; r.e_valid = ev; r.e_pc = ep; r.e_halt = eh;
    return r;
  endfunction

  vec_t        tbl[$];
  logic [23:0] dmem [16];

  initial begin
    for (int i = 0; i < 16; i++) dmem[i] = 24'h050000 + 24'(i);
    dmem[0] = 24'h004004; dmem[1] = 24'h113006; dmem[2] = 24'h0C6008; dmem[3] = 24'h123006;

    // Each row is one clock: inputs applied before the edge, outputs expected after it.
    tbl.push_back(mk(1, 0, 24'h004004, 0, 0, 0, 0, 24'h000000, 0, 0,  0));
    tbl.push_back(mk(1, 1, 24'h113006, 0, 0, 0, 0, 24'h000000, 0, 0,  0));
    tbl.push_back(mk(1, 2, 24'h0C6008, 0, 0, 0, 0, 24'h000000, 0, 0,  0));
    tbl.push_back(mk(1, 3, 24'h123006, 0, 0, 0, 0, 24'h000000, 0, 0,  0));
    tbl.push_back(mk(0, 0, 24'h000000, 1, 0, 0, 0, 24'h000000, 0, 0,  0));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 24'h004004, 1, 0,  0));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 24'h113006, 1, 1,  0));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 1, 0, 0, 24'h113006, 1, 1,  0));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 1, 0, 0, 24'h113006, 1, 1,  0));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 1, 0, 0, 24'h113006, 1, 1,  0));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 24'h0C6008, 1, 2,  0));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 24'h123006, 1, 3,  0));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 1, 1, 9, 24'h000000, 0, 3,  0));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 24'h050009, 1, 9,  0));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 24'h05000A, 1, 10, 0));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 24'h05000B, 1, 11, 0));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 24'h05000C, 1, 12, 0));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 24'h05000D, 1, 13, 0));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 24'h05000E, 1, 14, 0));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 24'h05000F, 1, 15, 0));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 24'h004004, 1, 0,  0));
    tbl.push_back(mk(1, 2, 24'h000000, 1, 0, 0, 0, 24'h113006, 1, 1,  0));
    tbl.push_back(mk(0, 0, 24'h000000, 0, 0, 0, 0, 24'h0C6008, 1, 2,  0));

    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 24'h0, 1'b0, 4'd0, 1'b0);
    rst_n = 1'b1;

    for (int i = 4; i < 16; i++) begin
      set_in(1, 4'(i), dmem[i], 0, 0, 0, 0);
      tick();
    end

    for (int r = 0; r < tbl.size(); r++) begin
      set_in(tbl[r].ld, tbl[r].la, tbl[r].ldat, tbl[r].st, tbl[r].fn, tbl[r].rv, tbl[r].rpc);
      tick();
      $display("row %0d: instr=%h valid=%0d pc_out=%0d halted=%0d",
               r, instruction_out, instr_valid, pc_out, halted);
      check_outs($sformatf("row%0d", r), tbl[r].e_instr, tbl[r].e_valid, tbl[r].e_pc, tbl[r].e_halt);
    end

    // Run on to pc 5, then pull reset mid-fetch.
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int k = 3; k <= 5; k++) begin
      tick();
      check_outs($sformatf("run_pc%0d", k), dmem[k], 1'b1, 4'(k), 1'b0);
    end
    #2 rst_n = 1'b0;
    #1;
    check_outs("async_reset", 24'h0, 1'b0, 4'd0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    $display("reset mid-run applied and released");

    // Plant a halt at pc 2 in the same cycle as start.
    set_in(1, 2, 24'hFC0000, 1, 0, 0, 0);
    tick();
    check_outs("start_load", 24'h0, 1'b0, 4'd0, 1'b0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    check_outs("restart_pc0", 24'h004004, 1'b1, 4'd0, 1'b0);
    tick();
    check_outs("restart_pc1", 24'h113006, 1'b1, 4'd1, 1'b0);
    tick();
    check_outs("halt_emit", 24'hFC0000, 1'b1, 4'd2, 1'b0);
    tick();
    check_outs("halt_enter", 24'hFC0000, 1'b0, 4'd2, 1'b1);
    for (int k = 0; k < 10; k++) begin
      set_in(1, 0, 24'h000000, 0, 1'($urandom_range(0, 1)), 1, 7);
      tick();
      check_outs($sformatf("halt_hold%0d", k), 24'hFC0000, 1'b0, 4'd2, 1'b1);
    end
    set_in(0, 0, 0, 1, 0, 0, 0);
    tick();
    check("halt_start.halted", 32'(halted), 32'd0);
    check("halt_start.valid", 32'(instr_valid), 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    check_outs("halt_restart_pc0", 24'h004004, 1'b1, 4'd0, 1'b0);
    tick();
    check_outs("halt_restart_pc1", 24'h113006, 1'b1, 4'd1, 1'b0);
    // Redirect in the cycle the halt opcode would be fetched.
    set_in(0, 0, 0, 0, 0, 1, 5);
    tick();
    check_outs("redir_over_halt", 24'h0, 1'b0, 4'd1, 1'b0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    check_outs("redir_target", 24'h050005, 1'b1, 4'd5, 1'b0);

    // Randomized run against the reference model.
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    check_outs("rand_reset", 24'h0, 1'b0, 4'd0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [23:0] d;
      d = 24'($urandom);
      if (d[23:18] == 6'h3F) d[23] = 1'b0;
      if ($urandom_range(0, 7) == 0) d[23:18] = 6'h3F;
      set_in(1, 4'(i), d, 0, 0, 0, 0);
      tick();
    end
    for (int c = 0; c < 400; c++) begin
      logic [23:0] d;
      d = 24'($urandom);
      if ($urandom_range(0, 7) == 0) d[23:18] = 6'h3F;
      set_in($urandom_range(0, 2) == 0, 4'($urandom), d,
             $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 9) == 0, 4'($urandom));
      tick();
      if (m_valid && instr_valid)
        $display("txn cycle %0d: pc_out=%0d instr=%h", c, pc_out, instruction_out);
      check_outs($sformatf("rand%0d", c), m_instr, m_valid, 4'(m_pcout), m_halted);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
